// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encodings and default frame geometry.
// The transmitter side can import the same defaults so both ends agree on the frame format.
package uart_rx_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high lines come out of reset without a false edge.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit validation, LSB-first shift, stop-bit check,
// and a one-deep holding register with valid/full/overrun/framing-error reporting.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud16,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rxdata,
    output logic                 rx_valid,
    output logic                 rx_full,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic w_rx_s;

    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic [TW-1:0]        r_tick;
    logic [TW-1:0]        w_tick_next;
    logic [BW-1:0]        r_bit;
    logic [BW-1:0]        w_bit_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_good;
    logic                 w_ferr;

    sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .i_clk  (clk),
        .i_reset(reset),
        .i_d    (rx),
        .o_q    (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_tick_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
        end
    end

    // The start bit is re-checked half a bit in, so every later sample lands mid-bit.
    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_good       = 1'b0;
        w_ferr       = 1'b0;
        if (baud16) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_next = ST_START;
                        w_tick_next  = '0;
                    end
                end
                ST_START: begin
                    if (r_tick == HALF_TICK) begin
                        w_tick_next = '0;
                        if (!w_rx_s) begin
                            w_state_next = ST_DATA;
                            w_bit_next   = '0;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_tick_next = r_tick + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_tick == FULL_TICK) begin
                        w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_tick_next  = '0;
                        w_bit_next   = r_bit + BW'(1);
                        if (r_bit == LAST_BIT) begin
                            w_state_next = ST_STOP;
                        end
                    end else begin
                        w_tick_next = r_tick + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_tick == FULL_TICK) begin
                        w_tick_next = '0;
                        if (w_rx_s) begin
                            w_good       = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_ferr       = 1'b1;
                            w_state_next = ST_BREAK;
                        end
                    end else begin
                        w_tick_next = r_tick + TW'(1);
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_tick_next  = '0;
                end
            endcase
        end
    end

    // A new byte wins over a same-cycle acknowledge, so rx_full stays set in that case.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxdata    <= '0;
            rx_valid  <= 1'b0;
            rx_full   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_valid  <= w_good;
            frame_err <= w_ferr;
            overrun   <= w_good && rx_full && !rx_ack;
            if (w_good) begin
                rxdata  <= r_shift;
                rx_full <= 1'b1;
            end else if (rx_ack) begin
                rx_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames from a bit-time model and compares
// received bytes, error pulses and the holding-register flag against a frame-level reference.
module tb_uart_rx;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       baud16 = 1'b0;
    logic       rx     = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rxdata;
    logic       rx_valid;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    int vecCnt  = 0;
    int missCnt = 0;

    // Observed activity, gathered once per clock on the falling edge.
    logic [7:0] gotQ[$];
    int         ferrCnt = 0;
    int         ovrCnt  = 0;

    // Frame-level reference state.
    logic [7:0] expQ[$];
    int         expFerr   = 0;
    int         expOvr    = 0;
    bit         modelFull = 1'b0;
    logic [7:0] modelData = 8'h00;

    uart_rx #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .baud16   (baud16),
        .rx       (rx),
        .rx_ack   (rx_ack),
        .rxdata   (rxdata),
        .rx_valid (rx_valid),
        .rx_full  (rx_full),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            baud16 = (div == 0);
            div    = (div + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (rx_valid === 1'b1) gotQ.push_back(rxdata);
        if (frame_err === 1'b1) ferrCnt++;
        if (overrun === 1'b1) ovrCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            missCnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after the n-th oversample tick edge.
    task automatic waitTicks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud16) @(posedge clk);
        end
        #1;
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        waitTicks(16);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        waitTicks(n);
    endtask

    task automatic ackPulse();
        rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
        modelFull = 1'b0;
        waitTicks(1);
    endtask

    // Stop-bit midpoint falls on tick 153 after the start edge: detection at tick 1
    // (two-flop delay), half a bit to the start check, then sixteen ticks per bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit ackAtStop);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(data[i]);
        rx = stopBit;
        if (ackAtStop) begin
            waitTicks(8);
            repeat (3) @(posedge clk);
            #1 rx_ack = 1'b1;
            @(posedge clk);
            #1 rx_ack = 1'b0;
            waitTicks(7);
        end else begin
            waitTicks(16);
        end
        if (stopBit) begin
            expQ.push_back(data);
            if (modelFull && !ackAtStop) expOvr++;
            modelFull = 1'b1;
            modelData = data;
        end else begin
            expFerr++;
        end
    endtask

    task automatic checkScenario(input string tag);
        int n;
        checkOutput({tag, "_count"}, 32'(gotQ.size()), 32'(expQ.size()));
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) checkOutput({tag, "_byte"}, 32'(gotQ[i]), 32'(expQ[i]));
        checkOutput({tag, "_rxdata"}, 32'(rxdata), 32'(modelData));
        checkOutput({tag, "_rx_full"}, 32'(rx_full), 32'(modelFull));
        checkOutput({tag, "_frame_err"}, 32'(ferrCnt), 32'(expFerr));
        checkOutput({tag, "_overrun"}, 32'(ovrCnt), 32'(expOvr));
        gotQ.delete();
        expQ.delete();
    endtask

    initial begin
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset_rxdata", 32'(rxdata), 32'h0);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'h0);
        checkOutput("reset_rx_full", 32'(rx_full), 32'h0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);
        idle(16);

        applyStimulus(8'hA5, 1'b1, 1'b0);
        idle(8);
        checkScenario("a5");
        ackPulse();
        checkOutput("ack_clears_full", 32'(rx_full), 32'h0);

        rx = 1'b0;
        waitTicks(4);
        idle(40);
        checkScenario("glitch");

        applyStimulus(8'h3C, 1'b0, 1'b0);
        waitTicks(32);
        idle(32);
        checkScenario("ferr");
        applyStimulus(8'h81, 1'b1, 1'b0);
        idle(8);
        checkScenario("after_ferr");
        ackPulse();

        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        idle(8);
        checkScenario("overrun");
        ackPulse();
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b1);
        idle(8);
        checkScenario("ack_same_clk");
        ackPulse();

        sendBit(1'b0);
        repeat (3) sendBit(1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        modelFull = 1'b0;
        modelData = 8'h00;
        checkOutput("midreset_rxdata", 32'(rxdata), 32'h0);
        checkOutput("midreset_rx_full", 32'(rx_full), 32'h0);
        checkOutput("midreset_pulses", {29'd0, rx_valid, frame_err, overrun}, 32'h0);
        repeat (6) sendBit(1'b1);
        idle(16);
        applyStimulus(8'h5A, 1'b1, 1'b0);
        idle(8);
        checkScenario("after_reset");
        ackPulse();

        applyStimulus(8'h00, 1'b1, 1'b0);
        ackPulse();
        applyStimulus(8'hFF, 1'b1, 1'b0);
        ackPulse();
        applyStimulus(8'h55, 1'b1, 1'b0);
        ackPulse();
        idle(8);
        checkScenario("b2b");

        for (int k = 0; k < 10; k++) begin
            logic [7:0] d;
            bit         doAck;
            d     = 8'($urandom);
            doAck = 1'($urandom_range(0, 1));
            idle($urandom_range(1, 20));
            applyStimulus(d, 1'b1, 1'b0);
            if (doAck) ackPulse();
        end
        idle(8);
        checkScenario("random");

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
